pixel_sink: RTL

Receiving end of the game's pixel-plot interface: consumes the `plot`/`X`/`Y`/`color` stream produced by the game top level and commits each pixel into the frame-buffer memory write port. Buffers requests in a small FIFO so bursts from the map and sprite drawers survive memory back-pressure. Provides a full-screen clear sequencer that paints the background colour. Sits between the game top level and the frame-buffer RAM/arbiter.

---
 rtl/mv_pkg.sv | 23 ++
 rtl/pixel_sink_if.sv | 26 ++
 rtl/pixel_fifo.sv | 45 ++++
 rtl/pixel_sink.sv | 126 ++++++++++++
 4 files changed

// File: rtl/mv_pkg.sv
// rtl/mv_pkg.sv - shared screen geometry, colour width and pixel-sink state encoding
package mv_pkg;

    localparam int SCREEN_W  = 320;
    localparam int SCREEN_H  = 240;
    localparam int COLOR_W   = 3;
    localparam int FB_ADDR_W = 17;
    localparam int COORD_X_W = 9;
    localparam int COORD_Y_W = 8;

    typedef enum logic {
        ST_PIXEL = 1'b0,
        ST_CLEAR = 1'b1
    } sink_state_t;

    // Row-major linear index computed at 32 bits so no partial product is truncated.
    function automatic logic [31:0] pixel_index(input logic [COORD_X_W-1:0] x,
                                                input logic [COORD_Y_W-1:0] y,
                                                input logic [31:0] width);
        return 32'(y) * width + 32'(x);
    endfunction

endpackage

// File: rtl/pixel_sink_if.sv
// rtl/pixel_sink_if.sv - pixel-plot request stream and frame-buffer write port
interface pixel_sink_if #(
    parameter int ADDR_W = mv_pkg::FB_ADDR_W
) ();
    import mv_pkg::*;

    logic                 plot;
    logic [COORD_X_W-1:0] X;
    logic [COORD_Y_W-1:0] Y;
    logic [COLOR_W-1:0]   color;
    logic                 mem_wren;
    logic [ADDR_W-1:0]    mem_addr;
    logic [COLOR_W-1:0]   mem_data;
    logic                 mem_ready;

    modport sink (
        input  plot, X, Y, color, mem_ready,
        output mem_wren, mem_addr, mem_data
    );

    modport master (
        output plot, X, Y, color, mem_ready,
        input  mem_wren, mem_addr, mem_data
    );

endinterface

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - synchronous power-of-two FIFO with flush; caller gates push on full and pop on empty
module pixel_fifo #(
    parameter  int DEPTH  = 8,
    parameter  int DATA_W = 20,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] store [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    // A push coinciding with flush lands in slot 0 of the emptied FIFO.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= push ? PTR_W'(1) : '0;
            count  <= push ? CNT_W'(1) : '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) store[flush ? '0 : wr_ptr] <= push_data;
    end

    assign head = store[rd_ptr];

endmodule

// File: rtl/pixel_sink.sv
// rtl/pixel_sink.sv - buffers plot requests into frame-buffer writes and sweeps a background clear
module pixel_sink
    import mv_pkg::*;
#(
    parameter int                 WIDTH    = SCREEN_W,
    parameter int                 HEIGHT   = SCREEN_H,
    parameter int                 DEPTH    = 8,
    parameter int                 ADDR_W   = FB_ADDR_W,
    parameter logic [COLOR_W-1:0] BG_COLOR = 3'b000
) (
    input  logic              clock,
    input  logic              resetn,
    pixel_sink_if.sink        pix,
    input  logic              clear,
    output logic              busy,
    output logic              clear_done,
    output logic              overflow,
    output logic              clipped
);

    localparam int                ENTRY_W   = ADDR_W + COLOR_W;
    localparam int                CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    sink_state_t        state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic               flush;
    logic               sweep_last;

    logic               on_screen;
    logic [ADDR_W-1:0]  push_addr;
    logic               fifo_full;
    logic               fifo_push;
    logic               fifo_pop;
    logic               drop_full;
    logic [ENTRY_W-1:0] fifo_head;
    logic [CNT_W-1:0]   fifo_count;

    assign on_screen = (32'(pix.X) < 32'(WIDTH)) && (32'(pix.Y) < 32'(HEIGHT));
    assign push_addr = ADDR_W'(pixel_index(pix.X, pix.Y, 32'(WIDTH)));
    assign fifo_full = (fifo_count == CNT_W'(DEPTH));

    // Fullness is judged on the registered count, but a clear empties the FIFO first.
    assign fifo_push = pix.plot && on_screen && (clear || !fifo_full);
    assign drop_full = pix.plot && on_screen && !clear && fifo_full;
    assign fifo_pop  = (state_q == ST_PIXEL) && !clear && (fifo_count != '0) && pix.mem_ready;

    pixel_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk       (clock),
        .resetn    (resetn),
        .flush     (flush),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .push_data ({push_addr, pix.color}),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= ST_PIXEL;
            cnt_q      <= '0;
            clear_done <= 1'b0;
            overflow   <= 1'b0;
            clipped    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clear_done <= sweep_last;
            overflow   <= overflow | drop_full;
            clipped    <= clipped | (pix.plot && !on_screen);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        flush      = 1'b0;
        sweep_last = 1'b0;
        case (state_q)
            ST_PIXEL: begin
                if (clear) begin
                    flush   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (clear) begin
                    flush = 1'b1;
                    cnt_d = '0;
                end else if (pix.mem_ready) begin
                    if (cnt_q == LAST_ADDR) begin
                        sweep_last = 1'b1;
                        cnt_d      = '0;
                        state_d    = ST_PIXEL;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = ST_PIXEL;
        endcase
    end

    // Write port depends only on registered state, counter and FIFO storage.
    always_comb begin
        pix.mem_wren = 1'b0;
        pix.mem_addr = '0;
        pix.mem_data = '0;
        if (state_q == ST_CLEAR) begin
            pix.mem_wren = 1'b1;
            pix.mem_addr = cnt_q;
            pix.mem_data = BG_COLOR;
        end else if (fifo_count != '0) begin
            pix.mem_wren = 1'b1;
            {pix.mem_addr, pix.mem_data} = fifo_head;
        end
    end

    assign busy = (state_q == ST_CLEAR) || (fifo_count != '0);

endmodule
